// File: rtl/pe_drain.sv
// Sequencer and output stage behind one MAC element. It runs one dot product and then
// rounds, shifts and saturates the accumulator into a 1-entry valid/ready output register.
module pe_drain #(
  parameter int BW    = 8,
  parameter int LEN_W = 8,
  parameter int SH_W  = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_length,
  input  logic [SH_W-1:0]   i_shift,
  input  logic [2*BW-1:0]   i_pe_sum,
  output logic              o_pe_clear,
  output logic              o_feed_en,
  output logic              o_busy,
  output logic [BW-1:0]     o_data,
  output logic              o_sat,
  output logic              o_valid,
  input  logic              i_ready
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FEED    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [LEN_W-1:0]   r_count;
  logic [LEN_W-1:0]   w_next_count;
  logic [SH_W-1:0]    r_shift;
  logic [SH_W-1:0]    w_next_shift;
  logic               w_capture;
  logic               w_out_free;
  logic [BW:0]        w_quant;
  logic [BW-1:0]      r_data;
  logic               r_sat;
  logic               r_valid;

  // Returns {sat, data}; the intermediate is one bit wider than the sum so the rounding add cannot wrap.
  function automatic logic [BW:0] quantize(input logic [2*BW-1:0] sum, input logic [SH_W-1:0] sh);
    logic [2*BW:0] v_round;
    logic [2*BW:0] v_res;
    if (sh != {SH_W{1'b0}}) begin
      v_round = (2*BW+1)'(1) << (sh - SH_W'(1));
    end else begin
      v_round = {(2*BW+1){1'b0}};
    end
    v_res = ({1'b0, sum} + v_round) >> sh;
    if (|v_res[2*BW:BW]) begin
      quantize = {1'b1, {BW{1'b1}}};
    end else begin
      quantize = {1'b0, v_res[BW-1:0]};
    end
  endfunction

  assign w_out_free = !r_valid || i_ready;
  assign w_quant    = quantize(i_pe_sum, r_shift);

  // State, length counter and latched shift.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_count <= {LEN_W{1'b0}};
      r_shift <= {SH_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_shift <= w_next_shift;
    end
  end

  // Next-state decode and PE/feeder controls.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_shift = r_shift;
    o_pe_clear   = 1'b1;
    o_feed_en    = 1'b0;
    o_busy       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_shift = i_shift;
          if (i_length != {LEN_W{1'b0}}) begin
            w_next_state = ST_FEED;
            w_next_count = i_length;
          end else begin
            w_next_state = ST_CAPTURE;
            w_next_count = {LEN_W{1'b0}};
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FEED: begin
        o_pe_clear   = 1'b0;
        o_feed_en    = 1'b1;
        o_busy       = 1'b1;
        w_next_count = r_count - LEN_W'(1);
        if (r_count == LEN_W'(1)) begin
          w_next_state = ST_CAPTURE;
        end else begin
          w_next_state = ST_FEED;
        end
      end
      ST_CAPTURE: begin
        o_busy = 1'b1;
        // While stalled the PE must keep its sum; the feeder drives zeros so it holds.
        if (w_out_free) begin
          o_pe_clear   = 1'b1;
          w_capture    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          o_pe_clear   = 1'b0;
          w_next_state = ST_CAPTURE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_count = {LEN_W{1'b0}};
      end
    endcase
  end

  // Output register with valid/ready handshake.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data  <= {BW{1'b0}};
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_data  <= w_quant[BW-1:0];
      r_sat   <= w_quant[BW];
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_data  = r_data;
  assign o_sat   = r_sat;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_pe_drain.sv
// Bench for pe_drain: a behavioural PE and feeder, directed jobs, and a scoreboard that
// checks every result handed off on o_valid & i_ready.
module tb_pe_drain;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_ready;
  logic [7:0]  i_length;
  logic [3:0]  i_shift;
  logic [15:0] acc;
  logic        o_pe_clear, o_feed_en, o_busy, o_sat, o_valid;
  logic [7:0]  o_data;

  logic [7:0]  act;
  logic [7:0]  wtab [0:3];
  logic [1:0]  fidx;
  logic [7:0]  op_a, op_w;
  logic [8:0]  sb [$];
  logic [8:0]  mon_exp;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  pe_drain #(.BW(8), .LEN_W(8), .SH_W(4)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_length(i_length),
    .i_shift(i_shift), .i_pe_sum(acc), .o_pe_clear(o_pe_clear), .o_feed_en(o_feed_en),
    .o_busy(o_busy), .o_data(o_data), .o_sat(o_sat), .o_valid(o_valid), .i_ready(i_ready)
  );

  assign op_a = o_feed_en ? act : 8'd0;
  assign op_w = o_feed_en ? wtab[fidx] : 8'd0;

  always @(posedge clk) begin
    if (o_pe_clear) acc <= 16'd0;
    else            acc <= acc + 16'(op_a) * 16'(op_w);
    if (o_pe_clear)     fidx <= 2'd0;
    else if (o_feed_en) fidx <= fidx + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!i_reset && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        chk("mon_unexpected", 32'(o_valid), 32'(0));
      end else begin
        mon_exp = sb.pop_front();
        chk("mon_data", 32'(o_data), 32'(mon_exp[7:0]));
        chk("mon_sat", 32'(o_sat), 32'(mon_exp[8]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len, input int sh);
    i_start  = 1'b1;
    i_length = 8'(len);
    i_shift  = 4'(sh);
    tick();
    i_start  = 1'b0;
  endtask

  // Runs one job with i_ready=1; checks feed count, latency, single valid pulse.
  task automatic run_job(input string tag, input int len, input int sh, input int exp_d, input int exp_s);
    int feeds;
    int valid_at;
    feeds = 0;
    valid_at = -1;
    sb.push_back({1'(exp_s), 8'(exp_d)});
    start(len, sh);
    for (int k = 1; k <= len + 2; k++) begin
      if (k > 1) tick();
      if (o_feed_en) feeds++;
      if (o_valid && valid_at < 0) valid_at = k;
    end
    chk({tag, "_feeds"}, 32'(feeds), 32'(len));
    chk({tag, "_latency"}, 32'(valid_at), 32'(len + 2));
    tick();
    chk({tag, "_pulse"}, 32'(o_valid), 32'(0));
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_length = 8'd0; i_shift = 4'd0;
    act = 8'd0;
    for (int i = 0; i < 4; i++) wtab[i] = 8'd0;
    tick(); tick();
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_clear", 32'(o_pe_clear), 32'(1));
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_data", 32'(o_data), 32'(0));
    i_reset = 1'b0;
    tick();

    act = 8'd128; wtab[0] = 8'd1; wtab[1] = 8'd2; wtab[2] = 8'd3;
    run_job("basic", 3, 2, 192, 0);
    run_job("sat", 3, 0, 255, 1);

    act = 8'd1; wtab[0] = 8'd3; wtab[1] = 8'd3;
    run_job("rnd6s2", 2, 2, 2, 0);
    run_job("rnd6s1", 2, 1, 3, 0);
    wtab[0] = 8'd2;
    run_job("rnd5s2", 2, 2, 1, 0);

    run_job("len0", 0, 3, 0, 0);

    // Backpressure: A pending, B stalls in CAPTURE.
    i_ready = 1'b0;
    act = 8'd10; wtab[0] = 8'd4;
    sb.push_back({1'b0, 8'd40});
    start(1, 0);
    tick(); tick();
    chk("bp_a_valid", 32'(o_valid), 32'(1));
    chk("bp_a_data", 32'(o_data), 32'(40));
    act = 8'd1; wtab[0] = 8'd7; wtab[1] = 8'd8;
    sb.push_back({1'b0, 8'd15});
    start(2, 0);
    tick(); tick(); tick();
    chk("bp_stall_busy", 32'(o_busy), 32'(1));
    chk("bp_stall_clear", 32'(o_pe_clear), 32'(0));
    chk("bp_stall_feed", 32'(o_feed_en), 32'(0));
    chk("bp_hold_data", 32'(o_data), 32'(40));
    tick();
    chk("bp_hold_data2", 32'(o_data), 32'(40));
    chk("bp_hold_valid", 32'(o_valid), 32'(1));
    i_ready = 1'b1;
    #1;
    chk("bp_release_clear", 32'(o_pe_clear), 32'(1));
    tick();
    chk("bp_b_valid", 32'(o_valid), 32'(1));
    chk("bp_b_data", 32'(o_data), 32'(15));
    chk("bp_b_idle", 32'(o_busy), 32'(0));
    tick();
    chk("bp_drained", 32'(o_valid), 32'(0));

    // Reset mid-FEED with a result still pending.
    i_ready = 1'b0;
    act = 8'd3; wtab[0] = 8'd3;
    start(1, 0);
    tick(); tick();
    chk("pre_rst_valid", 32'(o_valid), 32'(1));
    act = 8'd50; wtab[0] = 8'd1; wtab[1] = 8'd1; wtab[2] = 8'd1; wtab[3] = 8'd1;
    start(4, 0);
    tick();
    chk("mid_feed", 32'(o_feed_en), 32'(1));
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("mrst_busy", 32'(o_busy), 32'(0));
    chk("mrst_clear", 32'(o_pe_clear), 32'(1));
    chk("mrst_feed", 32'(o_feed_en), 32'(0));
    chk("mrst_valid", 32'(o_valid), 32'(0));
    chk("mrst_data", 32'(o_data), 32'(0));
    chk("mrst_sat", 32'(o_sat), 32'(0));
    i_ready = 1'b1;
    act = 8'd2; wtab[0] = 8'd5;
    run_job("post_rst", 1, 0, 10, 0);

    tick();
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pe_drain.md
Name: pe_drain

Overview:
- Controller and output stage directly downstream of one `pe` MAC element.
- Sequences one dot product: drives the PE clear, tells the upstream operand feeder when to present operands, and captures the PE's 2*BW accumulator once the last product has been added.
- Rounds, shifts and saturates the captured sum to BW bits, then holds it in a 1-entry output register with a valid/ready handshake toward the next layer's buffer.

Parameters:
- BW, 8: operand width of the PE; result width; the PE sum is 2*BW bits.
- LEN_W, 8: width of the dot-product length field.
- SH_W, 4: width of the shift field; shifts up to 2*BW-1 are legal.

Ports:
- i_clock  in  1  single clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request a new dot product; accepted only while o_busy=0.
- i_length  in  LEN_W  number of MAC cycles; sampled on start.
- i_shift  in  SH_W  right-shift applied to the sum; sampled on start.
- i_pe_sum  in  2*BW  PE o_output, unsigned.
- o_pe_clear  out  1  drives PE i_reset.
- o_feed_en  out  1  feeder presents a valid activation/weight pair this cycle; when 0 the feeder drives zeros.
- o_busy  out  1  high in any state except IDLE.
- o_data  out  BW  quantized result.
- o_sat  out  1  o_data was saturated; qualified by o_valid.
- o_valid  out  1  output register holds a result.
- i_ready  in  1  consumer accepts o_data when o_valid&i_ready.

Behaviour:
- PE model:
  - A clock edge with clear high sets acc to 0; otherwise acc <= acc + a*w.
  - o_output shows acc registered.
- States: IDLE, FEED, CAPTURE.
- IDLE:
  - o_pe_clear=1, o_feed_en=0, o_busy=0.
  - On i_start: latch len and shift.
  - If len!=0, go to FEED with counter=len; if len==0, go to CAPTURE.
- FEED:
  - o_pe_clear=0, o_feed_en=1, o_busy=1.
  - Counter decrements each cycle; after exactly len cycles, go to CAPTURE.
  - The product presented in FEED cycle k is added at the edge ending cycle k.
- CAPTURE:
  - o_feed_en=0, o_busy=1; i_pe_sum equals the final sum.
  - Capture occurs when the output register is free this cycle: o_valid=0, or o_valid&i_ready.
  - On capture: o_pe_clear=1 (same edge clears the PE), load o_data/o_sat, set o_valid=1, go to IDLE.
  - Otherwise: stall with o_pe_clear=0; the sum holds because operands are zero.
- Latency: i_start edge -> o_valid high after len+2 edges, absent backpressure.
- Quantize (unsigned, 2*BW+1-bit intermediate):
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >> shift.
  - If r > 2^BW-1: o_data = 2^BW-1 and o_sat=1; else o_data = r[BW-1:0] and o_sat=0.
- Output register:
  - o_valid clears on o_valid&i_ready unless reloaded in the same cycle.
  - o_data and o_sat hold stable while o_valid&!i_ready.
- i_start while o_busy=1 is ignored. A new job may start while o_valid=1 and the old result is still pending.
- Reset, including mid-FEED or mid-CAPTURE:
  - Next cycle: state=IDLE, o_pe_clear=1, o_feed_en=0, o_busy=0, o_valid=0, o_data=0, o_sat=0, counter=0.
  - Any partial sum is discarded.
- Length wrap: len = 2^LEN_W-1 is legal. Overflow of the PE's 2*BW accumulator is not detected here.

Test Plan:
- Basic dot product: start, len=3, shift=2; feeder act=128 with w=1,2,3 in FEED cycles; i_ready=1 -> o_feed_en high exactly 3 cycles; o_valid pulses once 5 edges after start with o_data=192 (768>>2), o_sat=0.
- Saturation: same operands, shift=0 -> o_data=255, o_sat=1.
- Rounding: len=2, act=1, w=3,3 (sum 6), shift=2 -> o_data=2; sum 5, shift=2 -> o_data=1; sum 6, shift=1 -> o_data=3.
- Backpressure: i_ready=0 with result A pending; second job completes -> stays in CAPTURE with o_pe_clear=0 and o_busy=1; o_data=A holds. Raise i_ready -> A is consumed and B loads on the same edge; o_valid stays high, then B is consumed.
- len=0: start -> no o_feed_en cycles; o_data=0 and o_valid after 2 edges.
- Reset mid-FEED (cycle 2 of len=4) -> next cycle IDLE with o_pe_clear=1, o_valid=0. A following len=1 job (act=2, w=5, shift=0) yields 10, with no contamination from the aborted job.
